// File: rtl/pipelined_add_sub_if.sv
// pipelined_add_sub_if: operand/result handshake bundle for pipelined_add_sub.
//   master (producer/consumer side): drives in_valid, A, B, select, out_ready
//                                    and observes in_ready, out_valid, Sum, flags
//   slave  (the adder):              the mirror image
//   WIDTH: operand/result width
interface pipelined_add_sub_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       select;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Sum;
   logic             negative;
   logic             zero;
   logic             carry_flag;
   logic             overflow;

   modport master (
      output in_valid, A, B, select, out_ready,
      input  in_ready, out_valid, Sum, negative, zero, carry_flag, overflow
   );

   modport slave (
      input  in_valid, A, B, select, out_ready,
      output in_ready, out_valid, Sum, negative, zero, carry_flag, overflow
   );
endinterface

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: STAGES-deep two's-complement add/sub with NZCV flags.
// Each stage adds one CHUNK = WIDTH/STAGES slice and registers the carry, so
// the critical path is a single chunk adder. Not-yet-used operand chunks ride
// along in skew registers; finished result chunks ride along in r_q, so every
// chunk of an op lines up at the last stage.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave side of pipelined_add_sub_if
//           in_valid/in_ready/A/B/select  - operand handshake
//           out_valid/out_ready/Sum/N/Z/C/V - result handshake
//   select: 3'b010 add, 3'b011 subtract, anything else passes A through
module pipelined_add_sub #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4
) (
   input  logic               clk,
   input  logic               reset,
   pipelined_add_sub_if.slave bus
);
   localparam int CH = WIDTH / STAGES;

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_add_sub: need 1 <= STAGES <= WIDTH and WIDTH divisible by STAGES");
   end

   logic             adv;
   logic             sub;
   logic             arith;
   logic [WIDTH-1:0] beff;

   // Global stall: everything moves only when the output slot can drain.
   assign adv          = !(bus.out_valid && !bus.out_ready);
   assign bus.in_ready = adv;

   assign sub   = (bus.select == 3'b011);
   assign arith = (bus.select[2:1] == 2'b01);
   // Pass-A is A + 0 + 0: Sum=A, no carry, and the V term cancels to 0.
   assign beff  = arith ? (sub ? ~bus.B : bus.B) : '0;

   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam bit LAST = (k == STAGES - 1);

      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] r_d;
      logic [WIDTH-1:0] r_q;     // low chunks: result so far, high chunks: A
      logic [CH-1:0]    a_ch;
      logic [CH-1:0]    b_ch;
      logic [CH-1:0]    s_ch;
      logic             cin;
      logic             cout;
      logic             zin;
      logic             vin;
      logic             zacc_d;
      logic             vld_q;
      logic             c_q;
      logic             zacc_q;  // running OR; inverted into the Z flag at the last stage

      if (k == 0) begin : g_src
         assign a_src = bus.A;
         assign b_ch  = beff[CH-1:0];
         assign cin   = sub;
         assign zin   = 1'b0;
         assign vin   = bus.in_valid;
      end else begin : g_src
         assign a_src = stg[k-1].r_q;
         assign b_ch  = stg[k-1].g_skew.b_q[CH-1:0];
         assign cin   = stg[k-1].c_q;
         assign zin   = stg[k-1].zacc_q;
         assign vin   = stg[k-1].vld_q;
      end

      assign a_ch           = a_src[k*CH +: CH];
      assign {cout, s_ch}   = {1'b0, a_ch} + {1'b0, b_ch} + {{CH{1'b0}}, cin};
      assign zacc_d         = LAST ? ~(zin | (|s_ch)) : (zin | (|s_ch));

      always_comb begin
         r_d                = a_src;
         r_d[k*CH +: CH]    = s_ch;
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            vld_q <= 1'b0;
         end else if (adv) begin
            vld_q <= vin;
         end
      end

      // Data loads only with a valid op so the outputs hold their last value
      // across bubbles.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_q    <= '0;
            c_q    <= 1'b0;
            zacc_q <= 1'b0;
         end else if (adv && vin) begin
            r_q    <= r_d;
            c_q    <= cout;
            zacc_q <= zacc_d;
         end
      end

      if (!LAST) begin : g_skew
         localparam int BW = WIDTH - (k + 1) * CH;
         logic [BW-1:0] b_d;
         logic [BW-1:0] b_q;     // Beff chunks not yet consumed

         if (k == 0) begin : g_bsrc
            assign b_d = beff[WIDTH-1:CH];
         end else begin : g_bsrc
            assign b_d = stg[k-1].g_skew.b_q[BW+CH-1:CH];
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               b_q <= '0;
            end else if (adv && vin) begin
               b_q <= b_d;
            end
         end
      end else begin : g_flags
         logic n_q;
         logic ov_q;

         // Carry into the MSB is recovered from the MSB sum bit.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               n_q  <= 1'b0;
               ov_q <= 1'b0;
            end else if (adv && vin) begin
               n_q  <= s_ch[CH-1];
               ov_q <= (a_ch[CH-1] ^ b_ch[CH-1] ^ s_ch[CH-1]) ^ cout;
            end
         end
      end
   end

   assign bus.out_valid  = stg[STAGES-1].vld_q;
   assign bus.Sum        = stg[STAGES-1].r_q;
   assign bus.negative   = stg[STAGES-1].g_flags.n_q;
   assign bus.zero       = stg[STAGES-1].zacc_q;
   assign bus.carry_flag = stg[STAGES-1].c_q;
   assign bus.overflow   = stg[STAGES-1].g_flags.ov_q;
endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor with NZCV flag generation.
- Successor to the single-cycle 64-bit ripple add/sub unit in the EX stage.
- Splits the WIDTH-bit operation into STAGES chunks. The carry is registered between chunks so the critical path is one chunk, not WIDTH bits.
- Carries a valid/ready handshake so the CPU pipeline can stall it.

Parameters:
- WIDTH, 64: operand/result width in bits. Must be divisible by STAGES; a failed check is an elaboration error.
- STAGES, 4: pipeline depth; each stage adds one CHUNK = WIDTH/STAGES slice. 1 ≤ STAGES ≤ WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operands present this cycle
- in_ready  output  1  unit accepts operands this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- select  input  3  ALU opcode: 3'b010 add, 3'b011 subtract; any other code is pass-A
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result this cycle
- Sum  output  WIDTH  result
- negative  output  1  N flag
- zero  output  1  Z flag
- carry_flag  output  1  C flag
- overflow  output  1  V flag

Behaviour:
- Reset (asynchronous, active-high):
  - All stage valid bits clear.
  - out_valid=0; Sum=0; negative, zero, carry_flag and overflow all 0.
  - In-flight operations are discarded, including on reset mid-stream.
- Advance enable: adv = !(out_valid && !out_ready).
  - in_ready = adv, combinational.
  - All stages shift together when adv=1 and hold when adv=0; this is a global stall.
  - Bubbles propagate as invalid stages; they are not collapsed.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Latency: exactly STAGES cycles from input transfer to out_valid with no stall. With continuous in_valid and out_ready, throughput is one op per cycle.
- Operation decode (registered at input with the operands):
  - sub = (select==3'b011).
  - arith = (select[2:1]==2'b01).
  - Pass-A (arith=0): Sum=A, carry_flag=0, overflow=0; N and Z are computed from A.
- Arithmetic:
  - Beff = sub ? ~B : B.
  - Carry-in to chunk 0 = sub.
  - Stage k computes Sum[k*CHUNK +: CHUNK] from A, Beff and the registered carry out of stage k-1.
- Skewing:
  - Upper operand chunks not yet consumed travel with the op through skew registers.
  - Lower result chunks already computed travel forward.
  - All chunks of one op emerge aligned in the same output cycle.
- Zero: a per-op running OR of completed result chunks is registered per stage. zero = ~(final OR).
- Final stage flags:
  - negative = Sum[WIDTH-1].
  - carry_flag = carry out of bit WIDTH-1. For subtract this means no borrow, i.e. A ≥ B unsigned.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Outputs:
  - Sum and all flags are registered and held stable while out_valid && !out_ready.
  - When out_valid=0 they hold their last value; a bench must not check them then.
- Simultaneous input and output transfer in the same cycle is legal: the pipeline shifts and no op is lost or duplicated.
- STAGES=1: single registered adder, latency 1, same handshake.
- Operations retire strictly in acceptance order.

Test Plan:
- WIDTH=64, STAGES=4, add 1+1, out_ready=1 → out_valid exactly 4 cycles after accept; Sum=2, N=0, Z=0, C=0, V=0.
- Subtract 5−5 → Sum=0, Z=1, C=1, N=0, V=0. Subtract 0−1 → Sum=0xFFFF_FFFF_FFFF_FFFF, N=1, C=0, V=0.
- Add 0x7FFF_FFFF_FFFF_FFFF+1 → Sum=0x8000_0000_0000_0000, N=1, V=1, C=0.
- Chunk-boundary carries:
  - 0x0000_0000_0000_FFFF+1 → 0x0000_0000_0001_0000.
  - 0xFFFF_FFFF_FFFF_FFFF+1 → Sum=0, Z=1, C=1, V=0.
- Stream 8 ops back-to-back, with out_ready=0 for 3 cycles after the 2nd result:
  - in_ready=0 during the stall and outputs stay stable.
  - All 8 results arrive in order with no duplicates.
  - select=3'b000 op with A=0 yields Sum=0, Z=1, C=0, V=0.
- Assert reset with 3 ops in flight → out_valid=0 and flags 0 immediately (asynchronous). After release, the first new op emerges after 4 cycles with no stale results. Repeat the first test at STAGES=1 and STAGES=8.
